// File: rtl/sdp_ram_8x4096_pkg.sv
// Shared defaults and helpers for the 8x4096 simple dual-port RAM.
// The defaults describe the stock build: 4096 words of 8 bits with
// single-cycle registered read data.
package sdp_ram_8x4096_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 12;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_OUTPUT_REG = 0;

  // Any non-zero OUTPUT_REG value selects the extra output pipeline stage.
  function automatic bit has_out_reg(input int output_reg);
    return output_reg != 0;
  endfunction

  // Number of rising edges from address presentation to valid rd_data.
  function automatic int read_latency(input int output_reg);
    return has_out_reg(output_reg) ? 2 : 1;
  endfunction

endpackage

// File: rtl/sdp_ram_8x4096_if.sv
// Bus bundle for the simple dual-port RAM.
//
// Signalling: there is no valid/ready handshake. wr_en is a single-cycle
// write strobe, sampled with wr_addr/wr_data on every rising clk. rd_addr
// is sampled on every rising clk; rd_data is the registered result,
// valid a fixed read latency later (1 edge, or 2 with the output register).
// The master drives addresses, write data and the strobe; the slave
// (the RAM) drives rd_data.
interface sdp_ram_8x4096_if
  import sdp_ram_8x4096_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/sdp_ram_8x4096_out_reg.sv
// Optional output pipeline stage for the RAM read path. Clears to zero
// while rst is high so that in-flight read data is discarded.
module sdp_ram_8x4096_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Register the array output, synchronous clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/sdp_ram_8x4096.sv
// Simple dual-port RAM: one write port, one read port, one clock.
// Behavioural stand-in for the vendor block RAM primitive. The array is
// written and read in a single clocked process so synthesis maps it onto
// block RAM. Reads are read-first: a read of the address being written
// in the same cycle returns the old contents. Array contents are never
// touched by reset; only the read pipeline is cleared.
module sdp_ram_8x4096
  import sdp_ram_8x4096_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OUTPUT_REG = DEFAULT_OUTPUT_REG
) (
  input  logic             clk,
  input  logic             rst,
  sdp_ram_8x4096_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage; power-up contents are undefined and there is no init file.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // First read stage, straight out of the array.
  logic [DATA_WIDTH-1:0] rd_q;

  // Value presented on the bus, after the optional output stage.
  logic [DATA_WIDTH-1:0] rd_out;

  // Array write plus registered read-first access; reset suppresses the
  // write and clears the read register but leaves the array alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      if (bus.wr_en) begin
        mem[bus.wr_addr] <= bus.wr_data;
      end
      rd_q <= mem[bus.rd_addr];
    end
  end

  // Optional second stage for timing closure on long output routes.
  if (has_out_reg(OUTPUT_REG)) begin : g_out_reg
    sdp_ram_8x4096_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
      .clk (clk),
      .rst (rst),
      .d   (rd_q),
      .q   (rd_out)
    );
  end else begin : g_no_out_reg
    assign rd_out = rd_q;
  end

  assign bus.rd_data = rd_out;

endmodule

// File: tb/tb_sdp_ram_8x4096.sv
// Bench for sdp_ram_8x4096. Two builds (OUTPUT_REG=0 and OUTPUT_REG=1)
// receive identical stimulus; each has its own expected-data queue and
// is checked by a monitor that follows the build's read latency.
module tb_sdp_ram_8x4096;

  localparam int AW = 12;
  localparam int DW = 8;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- stimulus nets
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic          rd_chk;

  sdp_ram_8x4096_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  sdp_ram_8x4096_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

  assign if0.wr_en   = wr_en;
  assign if0.wr_addr = wr_addr;
  assign if0.wr_data = wr_data;
  assign if0.rd_addr = rd_addr;
  assign if1.wr_en   = wr_en;
  assign if1.wr_addr = wr_addr;
  assign if1.wr_data = wr_data;
  assign if1.rd_addr = rd_addr;

  sdp_ram_8x4096 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  sdp_ram_8x4096 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // ---------------------------------------------------------------- scoreboard
  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [AW-1:0] adr_q0[$];
  logic [AW-1:0] adr_q1[$];

  task automatic check(input string name, input logic [AW-1:0] a,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s addr=0x%03h got=0x%02h want=0x%02h", name, a, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Present one cycle of stimulus; when chk is set, record what each build
  // must return for this read address once its latency has elapsed.
  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                       input logic chk, input logic [DW-1:0] e0,
                       input logic [DW-1:0] e1);
    rst     = r;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = ra;
    rd_chk  = chk;
    if (chk) begin
      exp_q0.push_back(e0);
      adr_q0.push_back(ra);
      exp_q1.push_back(e1);
      adr_q1.push_back(ra);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  // ---------------------------------------------------------------- monitor
  // Bit 0: a checked read was sampled at the last edge (1-cycle build).
  // Bit 1: sampled one edge earlier (2-cycle build).
  logic [1:0] chk_pipe = '0;

  always @(posedge clk) begin
    chk_pipe <= {chk_pipe[0], rd_chk};
  end

  always @(negedge clk) begin
    if (chk_pipe[0]) begin
      if (exp_q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL lat1_underflow got=0x%02h want=queued_entry", if0.rd_data);
      end else begin
        check("lat1_rd", adr_q0.pop_front(), if0.rd_data, exp_q0.pop_front());
      end
    end
    if (chk_pipe[1]) begin
      if (exp_q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL lat2_underflow got=0x%02h want=queued_entry", if1.rd_data);
      end else begin
        check("lat2_rd", adr_q1.pop_front(), if1.rd_data, exp_q1.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1_000_000;
    total++;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [AW-1:0] av;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    rd_chk  = 1'b0;

    // Reset held 20 cycles with moving read addresses: output must be 0.
    for (int i = 0; i < 20; i++) begin
      av = AW'(i * 37);
      drive(1'b1, 1'b0, '0, '0, av, 1'b1, 8'h00, 8'h00);
    end

    // Fill: mem[a] = 0xFF - a[7:0].
    for (int a = 0; a < 4096; a++) begin
      av = AW'(a);
      drive(1'b0, 1'b1, av, 8'(8'hFF - av[7:0]), '0, 1'b0, '0, '0);
    end

    // Sweep read of every address, one per cycle.
    for (int a = 0; a < 4096; a++) begin
      av = AW'(a);
      drive(1'b0, 1'b0, '0, '0, av, 1'b1, 8'(8'hFF - av[7:0]), 8'(8'hFF - av[7:0]));
    end

    // Read-first collision on 0x123.
    drive(1'b0, 1'b1, 12'h123, 8'h5A, 12'h000, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 12'h123, 8'hA5, 12'h123, 1'b1, 8'h5A, 8'h5A);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 12'h123, 1'b1, 8'hA5, 8'hA5);

    // Independent write and read in the same cycle.
    drive(1'b0, 1'b1, 12'h300, 8'h12, 12'h301, 1'b1, 8'hFE, 8'hFE);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 12'h300, 1'b1, 8'h12, 8'h12);

    // Strobe low: 0x010 keeps 0xEF.
    drive(1'b0, 1'b0, 12'h010, 8'h33, 12'h010, 1'b1, 8'hEF, 8'hEF);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 12'h010, 1'b1, 8'hEF, 8'hEF);
    idle();

    // Write attempted during reset is ignored.
    drive(1'b1, 1'b1, 12'h010, 8'h44, 12'h010, 1'b1, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 12'h010, 1'b1, 8'hEF, 8'hEF);

    // Mid-stream reset: the read issued alongside the write is still in
    // flight in the 2-stage build when reset hits, so it must come out 0.
    drive(1'b0, 1'b1, 12'h200, 8'h77, 12'h200, 1'b1, 8'hFF, 8'h00);
    drive(1'b1, 1'b0, 12'h000, 8'h00, 12'h200, 1'b1, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 12'h200, 1'b1, 8'h77, 8'h77);

    // Spot reads including the top address.
    drive(1'b0, 1'b0, 12'h000, 8'h00, 12'hFFF, 1'b1, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 12'h001, 1'b1, 8'hFE, 8'hFE);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 12'h123, 1'b1, 8'hA5, 8'hA5);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 12'h200, 1'b1, 8'h77, 8'h77);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 12'h010, 1'b1, 8'hEF, 8'hEF);

    // Drain the pipelines.
    for (int i = 0; i < 4; i++) begin
      idle();
    end

    // Every queued expectation must have been consumed.
    total++;
    if (exp_q0.size() != 0) begin
      bad++;
      $display("FAIL lat1_drain left=%0d want=0", exp_q0.size());
    end
    total++;
    if (exp_q1.size() != 0) begin
      bad++;
      $display("FAIL lat2_drain left=%0d want=0", exp_q1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
